// File: rtl/bpm_band_scheduler.sv
// Shares one autocorrelation engine across the low/mid/high flux bands and
// combines the per-band BPMs into a weighted estimate. Optional: BPM_RANGE_CLAMP_EN.
//
// state   | meaning
// IDLE    | no round active; waiting for a triple
// ISSUE   | eng_req high for the current band
// WAIT    | request accepted; waiting for eng_done or timeout
// COMBINE | weighted sum of the band BPMs is registered
module bpm_band_scheduler #(
    parameter int FW      = 74,
    parameter int W_LOW   = 2,
    parameter int W_MID   = 1,
    parameter int W_HIGH  = 2,
    parameter int SHIFT   = 2,
    parameter int TIMEOUT = 4096,
    parameter int MIN_BPM = 60,
    parameter int MAX_BPM = 200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flux_valid,
    input  logic [FW-1:0] flux_low,
    input  logic [FW-1:0] flux_mid,
    input  logic [FW-1:0] flux_high,
    output logic          eng_req,
    input  logic          eng_ready,
    output logic [1:0]    eng_band,
    output logic [FW-1:0] eng_flux,
    input  logic          eng_done,
    input  logic [15:0]   eng_bpm,
    output logic [15:0]   bpm_low,
    output logic [15:0]   bpm_mid,
    output logic [15:0]   bpm_high,
    output logic [15:0]   final_BPM_estimate,
    output logic          bpm_valid,
    output logic          timeout_err,
    output logic [7:0]    overrun_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMBINE} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = 26;

    state_t        state;
    logic [1:0]    band;
    logic [CW-1:0] wait_cnt;
    logic [FW-1:0] act_low, act_mid, act_high;
    logic [FW-1:0] pend_low, pend_mid, pend_high;
    logic          pend_valid;
    logic          consume, to_pend;
    logic [SW-1:0] sum, shifted;
    logic [15:0]   sat_bpm, wr_bpm;

    function automatic logic [15:0] clamp_bpm(input logic [15:0] v);
        if (v < 16'(MIN_BPM))      return 16'(MIN_BPM);
        else if (v > 16'(MAX_BPM)) return 16'(MAX_BPM);
        else                       return v;
    endfunction

    assign eng_req  = (state == ISSUE);
    assign eng_band = band;

    always_comb begin
        eng_flux = act_high;
        case (band)
            2'd0:    eng_flux = act_low;
            2'd1:    eng_flux = act_mid;
            default: eng_flux = act_high;
        endcase
    end

    always_comb begin
        sum     = SW'(bpm_low) * SW'(W_LOW) + SW'(bpm_mid) * SW'(W_MID)
                + SW'(bpm_high) * SW'(W_HIGH);
        shifted = sum >> SHIFT;
        sat_bpm = (|shifted[SW-1:16]) ? 16'hFFFF : shifted[15:0];
`ifdef BPM_RANGE_CLAMP_EN
        wr_bpm  = clamp_bpm(eng_bpm);
`else
        wr_bpm  = eng_bpm;
`endif
    end

    // Pending is drained whenever a new round can start from it this cycle.
    assign consume = pend_valid && (state == IDLE || state == COMBINE);
    assign to_pend = flux_valid && (state != IDLE || pend_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            band               <= 2'd0;
            wait_cnt           <= '0;
            act_low            <= '0;
            act_mid            <= '0;
            act_high           <= '0;
            pend_low           <= '0;
            pend_mid           <= '0;
            pend_high          <= '0;
            pend_valid         <= 1'b0;
            bpm_low            <= '0;
            bpm_mid            <= '0;
            bpm_high           <= '0;
            final_BPM_estimate <= '0;
            bpm_valid          <= 1'b0;
            timeout_err        <= 1'b0;
            overrun_cnt        <= '0;
        end else begin
            bpm_valid   <= 1'b0;
            timeout_err <= 1'b0;

            if (to_pend) begin
                pend_low   <= flux_low;
                pend_mid   <= flux_mid;
                pend_high  <= flux_high;
                pend_valid <= 1'b1;
                if (pend_valid && !consume && overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        act_low  <= pend_low;
                        act_mid  <= pend_mid;
                        act_high <= pend_high;
                        band     <= 2'd0;
                        state    <= ISSUE;
                    end else if (flux_valid) begin
                        act_low  <= flux_low;
                        act_mid  <= flux_mid;
                        act_high <= flux_high;
                        band     <= 2'd0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_ready) begin
                        wait_cnt <= CW'(TIMEOUT - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // A done in the terminal-count cycle takes precedence over the abort.
                    if (eng_done || wait_cnt == '0) begin
                        if (eng_done) begin
                            case (band)
                                2'd0:    bpm_low  <= wr_bpm;
                                2'd1:    bpm_mid  <= wr_bpm;
                                default: bpm_high <= wr_bpm;
                            endcase
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        if (band == 2'd2) begin
                            state <= COMBINE;
                        end else begin
                            band  <= band + 2'd1;
                            state <= ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                COMBINE: begin
                    final_BPM_estimate <= sat_bpm;
                    bpm_valid          <= 1'b1;
                    if (pend_valid) begin
                        act_low  <= pend_low;
                        act_mid  <= pend_mid;
                        act_high <= pend_high;
                        band     <= 2'd0;
                        state    <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bpm_band_scheduler.sv
// Directed self-checking bench for bpm_band_scheduler: a default-weight
// instance and a saturating-weight instance driven by one engine model.
module tb_bpm_band_scheduler;
    localparam int FW = 74;

    logic          clk = 1'b0;
    logic          reset, flux_valid, eng_ready, eng_done;
    logic [FW-1:0] flux_low, flux_mid, flux_high;
    logic [15:0]   eng_bpm;

    logic          eng_req, bpm_valid, timeout_err;
    logic [1:0]    eng_band;
    logic [FW-1:0] eng_flux;
    logic [15:0]   bpm_low, bpm_mid, bpm_high, final_est;
    logic [7:0]    overrun_cnt;

    logic          s_req, s_valid, s_to;
    logic [1:0]    s_band;
    logic [FW-1:0] s_flux;
    logic [15:0]   s_low, s_mid, s_high, s_final;
    logic [7:0]    s_ovr;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bpm_band_scheduler #(.FW(FW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .flux_valid(flux_valid),
        .flux_low(flux_low), .flux_mid(flux_mid), .flux_high(flux_high),
        .eng_req(eng_req), .eng_ready(eng_ready), .eng_band(eng_band),
        .eng_flux(eng_flux), .eng_done(eng_done), .eng_bpm(eng_bpm),
        .bpm_low(bpm_low), .bpm_mid(bpm_mid), .bpm_high(bpm_high),
        .final_BPM_estimate(final_est), .bpm_valid(bpm_valid),
        .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
    );

    bpm_band_scheduler #(.FW(FW), .W_LOW(255), .W_MID(255), .W_HIGH(255),
                         .SHIFT(0), .TIMEOUT(16)) dut_sat (
        .clk(clk), .reset(reset), .flux_valid(flux_valid),
        .flux_low(flux_low), .flux_mid(flux_mid), .flux_high(flux_high),
        .eng_req(s_req), .eng_ready(eng_ready), .eng_band(s_band),
        .eng_flux(s_flux), .eng_done(eng_done), .eng_bpm(eng_bpm),
        .bpm_low(s_low), .bpm_mid(s_mid), .bpm_high(s_high),
        .final_BPM_estimate(s_final), .bpm_valid(s_valid),
        .timeout_err(s_to), .overrun_cnt(s_ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [FW-1:0] l, input logic [FW-1:0] m, input logic [FW-1:0] h);
        flux_low = l; flux_mid = m; flux_high = h;
        flux_valid = 1'b1;
        tick();
        flux_valid = 1'b0;
    endtask

    // Engine model: accept the pending request, then pulse done lat cycles after acceptance.
    task automatic serve(input logic [15:0] bpm, input int lat, input bit give_done,
                         input logic [1:0] exp_band, input logic [FW-1:0] exp_flux);
        int n = 0;
        while (!eng_req && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("req_b%0d", exp_band), eng_req, 1);
        chk($sformatf("band_b%0d", exp_band), eng_band, exp_band);
        chk($sformatf("flux_b%0d", exp_band), eng_flux, exp_flux);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        chk($sformatf("req_drop_b%0d", exp_band), eng_req, 0);
        if (give_done) begin
            repeat (lat - 1) tick();
            eng_bpm  = bpm;
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
        end
    endtask

    logic [FW-1:0] fa_l = 74'h3_0000_0000_0000_0A01, fa_m = 74'h1_2345_6789_ABCD_0A02, fa_h = 74'h2_FFFF_0000_1111_0A03;
    logic [FW-1:0] fb_l = 74'h0_0000_0000_0000_0B01, fb_m = 74'h0_0000_0000_0000_0B02, fb_h = 74'h0_0000_0000_0000_0B03;
    logic [FW-1:0] fc_l = 74'h1_0000_0000_0000_0C01, fc_m = 74'h1_0000_0000_0000_0C02, fc_h = 74'h1_0000_0000_0000_0C03;
    logic [FW-1:0] fd_l = 74'h2_0000_0000_0000_0D01, fd_m = 74'h2_0000_0000_0000_0D02, fd_h = 74'h2_0000_0000_0000_0D03;
    logic [FW-1:0] fe_l = 74'h2_0000_0000_0000_0E01, fe_m = 74'h2_0000_0000_0000_0E02, fe_h = 74'h2_0000_0000_0000_0E03;
    logic [FW-1:0] ff_l = 74'h3_0000_0000_0000_0F01, ff_m = 74'h3_0000_0000_0000_0F02, ff_h = 74'h3_0000_0000_0000_0F03;

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1; flux_valid = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
        eng_bpm = '0; flux_low = '0; flux_mid = '0; flux_high = '0;
        repeat (3) tick();
        chk("rst_req", eng_req, 0);
        chk("rst_final", final_est, 0);
        chk("rst_valid", bpm_valid, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 1'b0;
        tick();

        // Single round: 120/100/140 -> (240+100+280)>>2 = 155
        pulse(fa_l, fa_m, fa_h);
        chk("lat_req", eng_req, 1);
        serve(16'd120, 5, 1, 2'd0, fa_l);
        serve(16'd100, 5, 1, 2'd1, fa_m);
        serve(16'd140, 5, 1, 2'd2, fa_h);
        chk("r1_low", bpm_low, 120);
        chk("r1_mid", bpm_mid, 100);
        chk("r1_high", bpm_high, 140);
        chk("r1_valid_early", bpm_valid, 0);
        tick();
        chk("r1_valid", bpm_valid, 1);
        chk("r1_final", final_est, 155);
        tick();
        chk("r1_valid_once", bpm_valid, 0);
        chk("r1_idle", eng_req, 0);

        // Prime bpm_mid = 90
        pulse(fb_l, fb_m, fb_h);
        serve(16'd120, 3, 1, 2'd0, fb_l);
        serve(16'd90, 3, 1, 2'd1, fb_m);
        serve(16'd140, 3, 1, 2'd2, fb_h);
        tick();
        chk("r2_final", final_est, 152);

        // Timeout on mid band
        pulse(fc_l, fc_m, fc_h);
        serve(16'd120, 3, 1, 2'd0, fc_l);
        serve(16'd0, 0, 0, 2'd1, fc_m);
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 40);
        chk("to_latency", n, 16);
        tick();
        chk("to_once", timeout_err, 0);
        serve(16'd140, 3, 1, 2'd2, fc_h);
        chk("to_mid_held", bpm_mid, 90);
        tick();
        chk("to_valid", bpm_valid, 1);
        chk("to_final", final_est, 152);

        // Pending + overrun: D starts, E pends, F overwrites E
        pulse(fd_l, fd_m, fd_h);
        serve(16'd100, 2, 1, 2'd0, fd_l);
        pulse(fe_l, fe_m, fe_h);
        serve(16'd100, 2, 1, 2'd1, fd_m);
        pulse(ff_l, ff_m, ff_h);
        chk("ovr_cnt", overrun_cnt, 1);
        serve(16'd100, 2, 1, 2'd2, fd_h);
        tick();
        chk("pd_valid", bpm_valid, 1);
        chk("pd_final", final_est, 125);
        chk("pd_req_next", eng_req, 1);
        serve(16'd80, 2, 1, 2'd0, ff_l);
        serve(16'd80, 2, 1, 2'd1, ff_m);
        serve(16'd80, 2, 1, 2'd2, ff_h);
        tick();
        chk("pd2_final", final_est, 100);
        chk("pd2_ovr", overrun_cnt, 1);

        // Saturation
        pulse(fa_l, fa_m, fa_h);
        serve(16'hFFFF, 2, 1, 2'd0, fa_l);
        serve(16'hFFFF, 2, 1, 2'd1, fa_m);
        serve(16'hFFFF, 2, 1, 2'd2, fa_h);
        tick();
        chk("sat_final", s_final, 16'hFFFF);
        chk("sat_dflt_final", final_est, 16'hFFFF);

        // Reset while waiting on the high band, then a stray done
        pulse(fb_l, fb_m, fb_h);
        serve(16'd100, 2, 1, 2'd0, fb_l);
        serve(16'd100, 2, 1, 2'd1, fb_m);
        serve(16'd0, 0, 0, 2'd2, fb_h);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_req", eng_req, 0);
        chk("mr_band", eng_band, 0);
        chk("mr_flux", eng_flux, 0);
        chk("mr_low", bpm_low, 0);
        chk("mr_mid", bpm_mid, 0);
        chk("mr_high", bpm_high, 0);
        chk("mr_final", final_est, 0);
        chk("mr_valid", bpm_valid, 0);
        chk("mr_to", timeout_err, 0);
        chk("mr_ovr", overrun_cnt, 0);
        chk("mr_sat_final", s_final, 0);
        eng_bpm = 16'd123;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            if (bpm_valid || timeout_err || eng_req) seen = 1'b1;
            tick();
        end
        chk("stray_done", seen, 0);
        chk("stray_high", bpm_high, 0);

        // Range clamp (or pass-through in the default build)
        pulse(fc_l, fc_m, fc_h);
        chk("idle_req", eng_req, 1);
        serve(16'd30, 2, 1, 2'd0, fc_l);
        serve(16'd250, 2, 1, 2'd1, fc_m);
        serve(16'd120, 2, 1, 2'd2, fc_h);
        tick();
`ifdef BPM_RANGE_CLAMP_EN
        chk("cl_low", bpm_low, 60);
        chk("cl_mid", bpm_mid, 200);
        chk("cl_high", bpm_high, 120);
        chk("cl_final", final_est, 140);
`else
        chk("cl_low", bpm_low, 30);
        chk("cl_mid", bpm_mid, 250);
        chk("cl_high", bpm_high, 120);
        chk("cl_final", final_est, 137);
`endif
        chk("cl_valid", bpm_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
